// File: rtl/instr_fetch.sv
// Fetch stage between the program counter and decode.
// Issues one ROM read per instruction, waits out the fixed ROM latency,
// then holds the instruction until decode takes it. A redirect drops any
// in-flight or held instruction so the reloaded PC is fetched next.
module instr_fetch #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 9,
    parameter int MEM_LAT = 2
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [ADDR_W-1:0]  PC,
    input  logic               Redirect,
    output logic               MemRdEn,
    output logic [ADDR_W-1:0]  MemAddr,
    input  logic [INSTR_W-1:0] MemData,
    output logic [INSTR_W-1:0] Instr,
    output logic [ADDR_W-1:0]  InstrPC,
    output logic               InstrValid,
    input  logic               DecReady,
    output logic               Advance,
    output logic [15:0]        FetchCnt
);

    // The wait counter is 3 bits wide, so latencies beyond 7 cannot be counted.
    generate
        if (MEM_LAT < 1 || MEM_LAT > 7) begin : g_bad_lat
            $error("instr_fetch: MEM_LAT must be in 1..7");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [2:0]         r_ctr;
    logic [ADDR_W-1:0]  r_req_pc;
    logic [INSTR_W-1:0] r_instr;
    logic [ADDR_W-1:0]  r_instr_pc;
    logic               r_valid;
    logic [15:0]        r_fetch_cnt;

    logic               w_issue;
    logic               w_capture;
    logic               w_accept;
    logic               w_drop;

    // Next state and per-cycle events; redirect always beats capture/accept.
    always_comb begin
        w_next    = r_state;
        w_issue   = 1'b0;
        w_capture = 1'b0;
        w_accept  = 1'b0;
        w_drop    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!Redirect) begin
                    w_issue = 1'b1;
                    w_next  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (Redirect) begin
                    w_next = S_IDLE;
                end else if (r_ctr == 3'd1) begin
                    w_capture = 1'b1;
                    w_next    = S_HOLD;
                end
            end
            S_HOLD: begin
                if (Redirect) begin
                    w_drop = 1'b1;
                    w_next = S_IDLE;
                end else if (DecReady) begin
                    w_accept = 1'b1;
                    w_next   = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge Clk) begin
        if (Reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Latency counter and the PC sampled at issue (PC may move afterwards).
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_ctr    <= 3'd0;
            r_req_pc <= '0;
        end else if (w_issue) begin
            r_ctr    <= 3'(MEM_LAT);
            r_req_pc <= PC;
        end else if (r_state == S_WAIT && r_ctr != 3'd0) begin
            r_ctr <= r_ctr - 3'd1;
        end
    end

    // Held instruction: captured at end of the wait, cleared on accept or flush.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_instr    <= '0;
            r_instr_pc <= '0;
            r_valid    <= 1'b0;
        end else if (w_capture) begin
            r_instr    <= MemData;
            r_instr_pc <= r_req_pc;
            r_valid    <= 1'b1;
        end else if (w_accept || w_drop) begin
            r_valid <= 1'b0;
        end
    end

    // Accepted-instruction counter, sticks at all-ones.
    always_ff @(posedge Clk) begin
        if (Reset)                                   r_fetch_cnt <= 16'd0;
        else if (w_accept && r_fetch_cnt != 16'hFFFF) r_fetch_cnt <= r_fetch_cnt + 16'd1;
    end

    assign MemRdEn    = w_issue & ~Reset;
    assign MemAddr    = PC;
    assign Advance    = w_accept & ~Reset;
    assign Instr      = r_instr;
    assign InstrPC    = r_instr_pc;
    assign InstrValid = r_valid;
    assign FetchCnt   = r_fetch_cnt;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: MEM_LAT=2 main instance plus
// MEM_LAT=1 and MEM_LAT=7 instances for latency and saturation checks.
module tb_instr_fetch;
    logic Clk;
    logic Reset;
    int   n_pass;
    int   n_tot;

    // ---------------- MEM_LAT = 2 ----------------
    logic [7:0] PC;
    logic       Redirect, DecReady;
    logic       MemRdEn, InstrValid, Advance;
    logic [7:0] MemAddr, InstrPC;
    logic [8:0] MemData, Instr;
    logic [15:0] FetchCnt;
    logic [8:0] rom2 [2];

    instr_fetch #(.ADDR_W(8), .INSTR_W(9), .MEM_LAT(2)) dut (
        .Clk(Clk), .Reset(Reset), .PC(PC), .Redirect(Redirect),
        .MemRdEn(MemRdEn), .MemAddr(MemAddr), .MemData(MemData),
        .Instr(Instr), .InstrPC(InstrPC), .InstrValid(InstrValid),
        .DecReady(DecReady), .Advance(Advance), .FetchCnt(FetchCnt));

    // ROM model: data for address a is {1,a} (= a + 0x100), junk 0x0AA otherwise.
    always @(posedge Clk) begin
        rom2[0] <= MemRdEn ? {1'b1, MemAddr} : 9'h0AA;
        rom2[1] <= rom2[0];
    end
    assign MemData = rom2[1];

    // ---------------- MEM_LAT = 1 ----------------
    logic [7:0] PC1;
    logic       Redirect1, DecReady1;
    logic       MemRdEn1, InstrValid1, Advance1;
    logic [7:0] MemAddr1, InstrPC1;
    logic [8:0] MemData1, Instr1;
    logic [15:0] FetchCnt1;
    logic [8:0] rom1;

    instr_fetch #(.ADDR_W(8), .INSTR_W(9), .MEM_LAT(1)) dut1 (
        .Clk(Clk), .Reset(Reset), .PC(PC1), .Redirect(Redirect1),
        .MemRdEn(MemRdEn1), .MemAddr(MemAddr1), .MemData(MemData1),
        .Instr(Instr1), .InstrPC(InstrPC1), .InstrValid(InstrValid1),
        .DecReady(DecReady1), .Advance(Advance1), .FetchCnt(FetchCnt1));

    always @(posedge Clk) rom1 <= MemRdEn1 ? {1'b1, MemAddr1} : 9'h0AA;
    assign MemData1 = rom1;

    // ---------------- MEM_LAT = 7 ----------------
    logic [7:0] PC7;
    logic       Redirect7, DecReady7;
    logic       MemRdEn7, InstrValid7, Advance7;
    logic [7:0] MemAddr7, InstrPC7;
    logic [8:0] MemData7, Instr7;
    logic [15:0] FetchCnt7;
    logic [8:0] rom7 [7];

    instr_fetch #(.ADDR_W(8), .INSTR_W(9), .MEM_LAT(7)) dut7 (
        .Clk(Clk), .Reset(Reset), .PC(PC7), .Redirect(Redirect7),
        .MemRdEn(MemRdEn7), .MemAddr(MemAddr7), .MemData(MemData7),
        .Instr(Instr7), .InstrPC(InstrPC7), .InstrValid(InstrValid7),
        .DecReady(DecReady7), .Advance(Advance7), .FetchCnt(FetchCnt7));

    always @(posedge Clk) begin
        rom7[0] <= MemRdEn7 ? {1'b1, MemAddr7} : 9'h0AA;
        for (int i = 1; i < 7; i++) rom7[i] <= rom7[i-1];
    end
    assign MemData7 = rom7[6];

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            #1;
            n_tot++; if (MemRdEn !== 1'b0)    $display("FAIL rst_rden got %0h exp 0", MemRdEn); else n_pass++;
            n_tot++; if (Advance !== 1'b0)    $display("FAIL rst_adv got %0h exp 0", Advance); else n_pass++;
            n_tot++; if (InstrValid !== 1'b0) $display("FAIL rst_valid got %0h exp 0", InstrValid); else n_pass++;
            n_tot++; if ({Instr, InstrPC} !== 17'h0) $display("FAIL rst_instr got %0h/%0h exp 0/0", Instr, InstrPC); else n_pass++;
            n_tot++; if (FetchCnt !== 16'h0)  $display("FAIL rst_cnt got %0h exp 0", FetchCnt); else n_pass++;
        end
        Reset = 1'b0;
        #1;
        n_tot++; if (MemRdEn !== 1'b1) $display("FAIL rel_rden got %0h exp 1", MemRdEn); else n_pass++;
        n_tot++; if (MemAddr !== 8'h0) $display("FAIL rel_addr got %0h exp 0", MemAddr); else n_pass++;
    endtask

    task automatic test_straight_line();
        int         n, nadv;
        int         cyc [3];
        logic [8:0] ins [3];
        logic [7:0] ipc [3];
        bit         adv_prev;
        n = 0; nadv = 0; adv_prev = 0;
        DecReady = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) begin
                step();
                if (adv_prev) PC = PC + 8'd1;
            end
            #1;
            if (Advance) begin
                nadv++;
                if (n < 3) begin
                    cyc[n] = c; ins[n] = Instr; ipc[n] = InstrPC; n++;
                end
            end
            adv_prev = Advance;
        end
        n_tot++; if (nadv !== 3) $display("FAIL sl_nadv got %0d exp 3", nadv); else n_pass++;
        for (int k = 0; k < 3; k++) begin
            n_tot++; if (ins[k] !== 9'h100 + 9'(k)) $display("FAIL sl_instr%0d got %0h exp %0h", k, ins[k], 9'h100 + 9'(k)); else n_pass++;
            n_tot++; if (ipc[k] !== 8'(k)) $display("FAIL sl_pc%0d got %0h exp %0h", k, ipc[k], k); else n_pass++;
            n_tot++; if (cyc[k] !== 4*k + 3) $display("FAIL sl_cyc%0d got %0d exp %0d", k, cyc[k], 4*k + 3); else n_pass++;
        end
        step();
        if (adv_prev) PC = PC + 8'd1;
        DecReady = 1'b0;
        #1;
        n_tot++; if (FetchCnt !== 16'd3)  $display("FAIL sl_cnt got %0d exp 3", FetchCnt); else n_pass++;
        n_tot++; if (InstrValid !== 1'b0) $display("FAIL sl_valid got %0h exp 0", InstrValid); else n_pass++;
        n_tot++; if (MemRdEn !== 1'b1 || MemAddr !== 8'h3) $display("FAIL sl_issue got %0h@%0h exp 1@3", MemRdEn, MemAddr); else n_pass++;
    endtask

    task automatic test_backpressure();
        step(); step(); step();
        #1;
        n_tot++; if (InstrValid !== 1'b1) $display("FAIL bp_valid got %0h exp 1", InstrValid); else n_pass++;
        for (int k = 0; k < 5; k++) begin
            PC = 8'h40 + 8'(k);
            #1;
            n_tot++; if (Instr !== 9'h103 || InstrPC !== 8'h3) $display("FAIL bp_hold%0d got %0h/%0h exp 103/3", k, Instr, InstrPC); else n_pass++;
            n_tot++; if (Advance !== 1'b0 || MemRdEn !== 1'b0) $display("FAIL bp_quiet%0d got adv %0h rden %0h exp 0 0", k, Advance, MemRdEn); else n_pass++;
            step();
        end
        DecReady = 1'b1;
        #1;
        n_tot++; if (Advance !== 1'b1) $display("FAIL bp_adv got %0h exp 1", Advance); else n_pass++;
        step();
        #1;
        n_tot++; if (InstrValid !== 1'b0) $display("FAIL bp_clr got %0h exp 0", InstrValid); else n_pass++;
        n_tot++; if (FetchCnt !== 16'd4)  $display("FAIL bp_cnt got %0d exp 4", FetchCnt); else n_pass++;
        n_tot++; if (MemRdEn !== 1'b1 || MemAddr !== 8'h44) $display("FAIL bp_idle got %0h@%0h exp 1@44", MemRdEn, MemAddr); else n_pass++;
    endtask

    task automatic test_flush_wait_hold();
        bit got;
        int gap;
        PC = 8'h05;
        DecReady = 1'b0;
        #1;
        n_tot++; if (MemRdEn !== 1'b1 || MemAddr !== 8'h05) $display("FAIL fw_issue got %0h@%0h exp 1@5", MemRdEn, MemAddr); else n_pass++;
        step();
        Redirect = 1'b1;
        PC = 8'h20;
        #1;
        n_tot++; if (MemRdEn !== 1'b0 || Advance !== 1'b0) $display("FAIL fw_wait got rden %0h adv %0h exp 0 0", MemRdEn, Advance); else n_pass++;
        step();
        Redirect = 1'b0;
        #1;
        n_tot++; if (MemRdEn !== 1'b1 || MemAddr !== 8'h20) $display("FAIL fw_reissue got %0h@%0h exp 1@20", MemRdEn, MemAddr); else n_pass++;
        n_tot++; if (InstrValid !== 1'b0) $display("FAIL fw_valid got %0h exp 0", InstrValid); else n_pass++;
        got = 0; gap = 0;
        for (int c = 1; c <= 10 && !got; c++) begin
            step();
            #1;
            if (InstrValid) begin got = 1; gap = c; end
        end
        n_tot++; if (gap !== 3) $display("FAIL fw_gap got %0d exp 3", gap); else n_pass++;
        n_tot++; if (InstrPC !== 8'h20 || Instr !== 9'h120) $display("FAIL fw_first got %0h/%0h exp 120/20", Instr, InstrPC); else n_pass++;
        // flush while held, with decode ready in the same cycle
        DecReady = 1'b1;
        Redirect = 1'b1;
        #1;
        n_tot++; if (Advance !== 1'b0) $display("FAIL fh_adv got %0h exp 0", Advance); else n_pass++;
        step();
        Redirect = 1'b0;
        DecReady = 1'b0;
        #1;
        n_tot++; if (InstrValid !== 1'b0) $display("FAIL fh_valid got %0h exp 0", InstrValid); else n_pass++;
        n_tot++; if (FetchCnt !== 16'd4)  $display("FAIL fh_cnt got %0d exp 4", FetchCnt); else n_pass++;
        n_tot++; if (MemRdEn !== 1'b1)    $display("FAIL fh_idle got %0h exp 1", MemRdEn); else n_pass++;
    endtask

    task automatic test_mem_lat_1();
        bit got;
        int gap;
        Redirect1 = 1'b0;
        PC1 = 8'h10;
        #1;
        n_tot++; if (MemRdEn1 !== 1'b1 || MemAddr1 !== 8'h10) $display("FAIL l1_issue got %0h@%0h exp 1@10", MemRdEn1, MemAddr1); else n_pass++;
        got = 0; gap = 0;
        for (int c = 1; c <= 10 && !got; c++) begin
            step();
            #1;
            if (InstrValid1) begin got = 1; gap = c; end
        end
        n_tot++; if (gap !== 2) $display("FAIL l1_gap got %0d exp 2", gap); else n_pass++;
        n_tot++; if (Instr1 !== 9'h110 || InstrPC1 !== 8'h10) $display("FAIL l1_instr got %0h/%0h exp 110/10", Instr1, InstrPC1); else n_pass++;
        n_tot++; if (FetchCnt1 !== 16'd0) $display("FAIL l1_cnt0 got %0h exp 0", FetchCnt1); else n_pass++;
        force dut1.r_fetch_cnt = 16'hFFFF;
        #1;
        release dut1.r_fetch_cnt;
        DecReady1 = 1'b1;
        #1;
        n_tot++; if (Advance1 !== 1'b1) $display("FAIL l1_adv got %0h exp 1", Advance1); else n_pass++;
        step();
        Redirect1 = 1'b1;
        DecReady1 = 1'b0;
        #1;
        n_tot++; if (FetchCnt1 !== 16'hFFFF) $display("FAIL l1_sat got %0h exp ffff", FetchCnt1); else n_pass++;
    endtask

    task automatic test_mem_lat_7();
        bit got;
        int gap;
        Redirect7 = 1'b0;
        PC7 = 8'h33;
        #1;
        n_tot++; if (MemRdEn7 !== 1'b1 || MemAddr7 !== 8'h33) $display("FAIL l7_issue got %0h@%0h exp 1@33", MemRdEn7, MemAddr7); else n_pass++;
        got = 0; gap = 0;
        for (int c = 1; c <= 14 && !got; c++) begin
            step();
            #1;
            if (InstrValid7) begin got = 1; gap = c; end
        end
        n_tot++; if (gap !== 8) $display("FAIL l7_gap got %0d exp 8", gap); else n_pass++;
        n_tot++; if (Instr7 !== 9'h133 || InstrPC7 !== 8'h33) $display("FAIL l7_instr got %0h/%0h exp 133/33", Instr7, InstrPC7); else n_pass++;
        DecReady7 = 1'b1;
        step();
        Redirect7 = 1'b1;
        DecReady7 = 1'b0;
        #1;
        n_tot++; if (FetchCnt7 !== 16'd1) $display("FAIL l7_cnt got %0d exp 1", FetchCnt7); else n_pass++;
    endtask

    initial begin
        n_pass = 0; n_tot = 0;
        Reset = 1'b1;
        PC = 8'h0;  Redirect = 1'b0;  DecReady = 1'b0;
        PC1 = 8'h0; Redirect1 = 1'b1; DecReady1 = 1'b0;
        PC7 = 8'h0; Redirect7 = 1'b1; DecReady7 = 1'b0;
        test_reset();
        test_straight_line();
        test_backpressure();
        test_flush_wait_hold();
        test_mem_lat_1();
        test_mem_lat_7();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
